multi_clock_divider: RTL

Parametrised multi-channel clock divider for the timing path of the design. It generates CHANNELS independent square waves and matching one-cycle rising-edge ticks from a single system clock. Each channel has a half-period that software can reprogram at runtime, its own enable, and a shared phase-align input. It supersedes single fixed-ratio dividers: stopwatch count, blink and adjust rates all come from one instance.

---
 rtl/multi_clock_divider_if.sv | 22 ++
 rtl/multi_clock_divider.sv | 66 ++++++
 2 files changed

// File: rtl/multi_clock_divider_if.sv
// Half-period programming bus for multi_clock_divider: a write strobe, a channel
// index and the new half-period value, all sampled on the divider clock.
interface multi_clock_divider_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
);
    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output wr_en,
        output wr_sel,
        output wr_data
    );

    modport slave (
        input wr_en,
        input wr_sel,
        input wr_data
    );
endinterface

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: per-channel 50% square wave plus a one-cycle
// rising-edge tick, with runtime half-period writes, per-channel enable and shared phase-align.
module multi_clock_divider #(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 32,
    parameter int SEL_W        = 2,
    parameter int DEFAULT_HALF = 50
) (
    input  logic                 in,
    input  logic                 rst,
    input  logic [CHANNELS-1:0]  en,
    input  logic                 sync,
    multi_clock_divider_if.slave bus,
    output logic [CHANNELS-1:0]  out,
    output logic [CHANNELS-1:0]  tick
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] half_q;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] term_cnt;
        logic             out_q;
        logic             tick_q;
        logic             wr_hit;
        logic             at_term;

        // Indices at or above CHANNELS never match any channel, so such writes drop out here.
        assign wr_hit   = bus.wr_en && (bus.wr_sel == SEL_W'(g));
        assign term_cnt = (half_q == '0) ? '0 : (half_q - WIDTH'(1));
        assign at_term  = (cnt_q == term_cnt);

        always_ff @(posedge in) begin
            if (rst) begin
                half_q <= WIDTH'(DEFAULT_HALF);
                cnt_q  <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                if (wr_hit) begin
                    half_q <= bus.wr_data;
                end
                // A write restarts the phase, so the old half-period never meets the new count.
                if (sync || wr_hit) begin
                    cnt_q  <= '0;
                    out_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (en[g]) begin
                    if (at_term) begin
                        cnt_q  <= '0;
                        out_q  <= ~out_q;
                        tick_q <= ~out_q;
                    end else begin
                        cnt_q  <= cnt_q + WIDTH'(1);
                        tick_q <= 1'b0;
                    end
                end else begin
                    tick_q <= 1'b0;
                end
            end
        end

        assign out[g]  = out_q;
        assign tick[g] = tick_q;
    end

endmodule
